dma_transfer_timing_ctrl: RTL and testbench

- Transfer sequencer downstream of the priority logic in the 8237-style DMA controller.
- Takes the winning channel and its request-pending indication, and runs the HRQ/HLDA bus handshake.
- Generates the S0–S4 transfer timing, counts words and detects terminal count (TC).
- Drives assertDACK back to the priority logic, which converts it to the one-hot DACK on the bus interface.

---
 rtl/dma_transfer_timing_ctrl_if.sv | 49 ++++
 rtl/dma_transfer_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_dma_transfer_timing_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_transfer_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_transfer_timing_ctrl_if
// Description : Handshake/bus bundle between the DMA transfer sequencer, the
//               priority logic, the CPU hold handshake and the bus strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_transfer_timing_ctrl_if #(
    parameter int COUNT_W = 16,
    parameter int NUM_CH  = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               requestPending;
    logic [CH_W-1:0]    grantedChannel;
    logic               HLDA;
    logic [COUNT_W-1:0] wordCountIn;
    logic               blockMode;
    logic [1:0]         transferType;
    logic               EOP_N_in;

    logic               HRQ;
    logic               assertDACK;
    logic [CH_W-1:0]    activeChannel;
    logic               AEN;
    logic               ADSTB;
    logic               MEMR_N;
    logic               MEMW_N;
    logic               IOR_N;
    logic               IOW_N;
    logic               EOP_N_out;
    logic               decCount;
    logic [NUM_CH-1:0]  tcChannel;

    modport slave (
        input  requestPending, grantedChannel, HLDA, wordCountIn,
               blockMode, transferType, EOP_N_in,
        output HRQ, assertDACK, activeChannel, AEN, ADSTB,
               MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, decCount, tcChannel
    );

    modport master (
        output requestPending, grantedChannel, HLDA, wordCountIn,
               blockMode, transferType, EOP_N_in,
        input  HRQ, assertDACK, activeChannel, AEN, ADSTB,
               MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, decCount, tcChannel
    );
endinterface
`default_nettype wire

// File: rtl/dma_transfer_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_transfer_timing_ctrl
// Description : 8237-style transfer sequencer: HRQ/HLDA handshake, S0-S4
//               timing, word counting and terminal-count detection.
//               Optional macro COMPRESSED_TIMING_EN drops S3 (2 clocks/word).
// Revision    : 1.0 - initial release
// ============================================================================
module dma_transfer_timing_ctrl #(
    parameter int COUNT_W = 16,
    parameter int NUM_CH  = 4
) (
    input logic                       CLK,
    input logic                       RESET,
    dma_transfer_timing_ctrl_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_S4 = 3'd5;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [COUNT_W-1:0] count;
    logic [CH_W-1:0]    active_channel;
    logic               ext_eop;
    logic               end_of_block;
    logic               tc_now;
    logic               read_side;
    logic               write_side;
    logic               is_write;
    logic               is_read;
    logic [NUM_CH-1:0]  tc_onehot;

    logic               hrq;
    logic               dack;
    logic               aen;
    logic               adstb;
    logic               memr_n;
    logic               memw_n;
    logic               ior_n;
    logic               iow_n;
    logic               eop_n;
    logic               dec_count;
    logic [NUM_CH-1:0]  tc_channel;

    // eop_n is low only while sitting in a TC S4, so it doubles as the TC flag here
    assign end_of_block = !eop_n || ext_eop || !bus.EOP_N_in || !bus.blockMode;
    assign tc_now       = (state_nxt == ST_S4) && (count == '0);
    assign is_write     = (bus.transferType == 2'b01);
    assign is_read      = (bus.transferType == 2'b10);
    assign tc_onehot    = NUM_CH'(1) << active_channel;

`ifdef COMPRESSED_TIMING_EN
    assign read_side  = (state_nxt == ST_S2);
    assign write_side = (state_nxt == ST_S2);
`else
    assign read_side  = (state_nxt == ST_S2) || (state_nxt == ST_S3);
    assign write_side = (state_nxt == ST_S3);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SI: if (bus.requestPending) state_nxt = ST_S0;
            ST_S0: begin
                if (bus.HLDA)                 state_nxt = ST_S1;
                else if (!bus.requestPending) state_nxt = ST_SI;
            end
            ST_S1: state_nxt = bus.HLDA ? ST_S2 : ST_SI;
`ifdef COMPRESSED_TIMING_EN
            ST_S2: state_nxt = bus.HLDA ? ST_S4 : ST_SI;
`else
            ST_S2: state_nxt = bus.HLDA ? ST_S3 : ST_SI;
`endif
            ST_S3: state_nxt = bus.HLDA ? ST_S4 : ST_SI;
            ST_S4: state_nxt = (!bus.HLDA || end_of_block) ? ST_SI : ST_S2;
            default: state_nxt = ST_SI;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_SI;
            count          <= '0;
            active_channel <= '0;
            ext_eop        <= 1'b0;
            hrq            <= 1'b0;
            dack           <= 1'b0;
            aen            <= 1'b0;
            adstb          <= 1'b0;
            memr_n         <= 1'b1;
            memw_n         <= 1'b1;
            ior_n          <= 1'b1;
            iow_n          <= 1'b1;
            eop_n          <= 1'b1;
            dec_count      <= 1'b0;
            tc_channel     <= '0;
        end else begin
            state     <= state_nxt;
            hrq       <= (state_nxt != ST_SI);
            aen       <= (state_nxt != ST_SI) && (state_nxt != ST_S0);
            dack      <= (state_nxt != ST_SI) && (state_nxt != ST_S0);
            adstb     <= (state_nxt == ST_S1);
            dec_count <= (state_nxt == ST_S4);
            ior_n     <= !(is_write && read_side);
            memw_n    <= !(is_write && write_side);
            memr_n    <= !(is_read && read_side);
            iow_n     <= !(is_read && write_side);
            eop_n     <= !tc_now;
            tc_channel <= tc_now ? tc_onehot : '0;

            if ((state == ST_S0) && (state_nxt == ST_S1)) begin
                active_channel <= bus.grantedChannel;
                count          <= bus.wordCountIn;
            end else if (state_nxt == ST_S4) begin
                count <= count - COUNT_W'(1);
            end

            // A low EOP seen in S2/S3 ends the block at the following S4
            if (state_nxt == ST_SI)
                ext_eop <= 1'b0;
            else if (((state == ST_S2) || (state == ST_S3)) && !bus.EOP_N_in)
                ext_eop <= 1'b1;
        end
    end

    assign bus.HRQ           = hrq;
    assign bus.assertDACK    = dack;
    assign bus.activeChannel = active_channel;
    assign bus.AEN           = aen;
    assign bus.ADSTB         = adstb;
    assign bus.MEMR_N        = memr_n;
    assign bus.MEMW_N        = memw_n;
    assign bus.IOR_N         = ior_n;
    assign bus.IOW_N         = iow_n;
    assign bus.EOP_N_out     = eop_n;
    assign bus.decCount      = dec_count;
    assign bus.tcChannel     = tc_channel;
endmodule
`default_nettype wire

// File: tb/tb_dma_transfer_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_transfer_timing_ctrl
// Description : Randomised transaction-level bench for dma_transfer_timing_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_transfer_timing_ctrl;
    localparam int COUNT_W = 16;
    localparam int NUM_CH  = 4;
`ifdef COMPRESSED_TIMING_EN
    localparam int CPW      = 2;  // clocks per word
    localparam int RD_PER_W = 1;  // read-side strobe low clocks per word
`else
    localparam int CPW      = 3;
    localparam int RD_PER_W = 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    dma_transfer_timing_ctrl_if #(.COUNT_W(COUNT_W), .NUM_CH(NUM_CH)) bus ();

    dma_transfer_timing_ctrl #(.COUNT_W(COUNT_W), .NUM_CH(NUM_CH)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hrq"}, bus.HRQ, 1'b0);
        check({tag, "_dack"}, {bus.assertDACK, bus.AEN, bus.ADSTB, bus.decCount}, 4'b0000);
        check({tag, "_strobes"}, {bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N, bus.EOP_N_out}, 5'h1f);
        check({tag, "_tc"}, bus.tcChannel, 4'b0000);
    endtask

    task automatic start(input int count, input bit block, input logic [1:0] ttype, input int chan);
        bus.grantedChannel = chan[1:0];
        bus.wordCountIn    = count[COUNT_W-1:0];
        bus.blockMode      = block;
        bus.transferType   = ttype;
        bus.EOP_N_in       = 1'b1;
        bus.HLDA           = 1'b0;
        bus.requestPending = 1'b1;
    endtask

    // eop_word: 0 = no external EOP, k = EOP driven low during word k
    task automatic run_txn(input int count, input bit block, input logic [1:0] ttype,
                           input int chan, input int eop_word, input int lat);
        int words, dack_cycles, pulses, eops, rd_low, wr_low, bad_low, adstb_extra;
        logic [3:0] tcv;
        bit exp_tc, done, first, rd_s, wr_s;

        words  = block ? count + 1 : 1;
        if (eop_word != 0 && eop_word < words) words = eop_word;
        exp_tc = (words == count + 1);

        start(count, block, ttype, chan);
        tick();
        check("s0_hrq", {bus.HRQ, bus.assertDACK}, 2'b10);
        repeat (lat) tick();
        check("s0_wait_hrq", {bus.HRQ, bus.assertDACK}, 2'b10);
        bus.HLDA = 1'b1;
        tick();
        check("s1_flags", {bus.AEN, bus.ADSTB, bus.assertDACK}, 3'b111);
        check("s1_chan", bus.activeChannel, chan[1:0]);
        bus.requestPending = 1'b0;

        dack_cycles = 1; pulses = 0; eops = 0; rd_low = 0; wr_low = 0;
        bad_low = 0; adstb_extra = 0; tcv = '0; done = 0; first = 1;
        for (int c = 0; c < CPW * words + 10; c++) begin
            if (eop_word != 0 && bus.EOP_N_in && !bus.decCount && pulses == eop_word - 1)
                bus.EOP_N_in = 1'b0;
            tick();
            if (!bus.assertDACK) begin
                done = 1;
                break;
            end
            dack_cycles++;
            rd_s = (ttype == 2'b01) ? !bus.IOR_N  : (ttype == 2'b10) ? !bus.MEMR_N : 1'b0;
            wr_s = (ttype == 2'b01) ? !bus.MEMW_N : (ttype == 2'b10) ? !bus.IOW_N  : 1'b0;
            if (first && ttype inside {2'b01, 2'b10}) begin
                check("s2_strobes", {rd_s, wr_s}, {1'b1, CPW == 2});
            end
            first = 0;
            rd_low  += int'(rd_s);
            wr_low  += int'(wr_s);
            bad_low += 4 - int'(bus.MEMR_N) - int'(bus.MEMW_N) - int'(bus.IOR_N)
                       - int'(bus.IOW_N) - int'(rd_s) - int'(wr_s);
            pulses  += int'(bus.decCount);
            adstb_extra += int'(bus.ADSTB);
            if (!bus.EOP_N_out) begin
                eops++;
                tcv = bus.tcChannel;
            end
        end
        check("done_in_time", done, 1'b1);
        check("si_hrq_aen", {bus.HRQ, bus.AEN, bus.decCount}, 3'b000);
        check("words", pulses, words);
        check("dack_cycles", dack_cycles, 1 + CPW * words);
        check("tc_count", eops, exp_tc);
        if (exp_tc) check("tc_channel", tcv, 4'b0001 << chan);
        check("rd_low", rd_low, (ttype inside {2'b01, 2'b10}) ? RD_PER_W * words : 0);
        check("wr_low", wr_low, (ttype inside {2'b01, 2'b10}) ? words : 0);
        check("stray_strobe", bad_low, 0);
        check("adstb_once", adstb_extra, 0);
        bus.HLDA     = 1'b0;
        bus.EOP_N_in = 1'b1;
        tick();
        check_idle("post_txn");
    endtask

    initial begin
        bus.requestPending = 1'b0;
        bus.grantedChannel = '0;
        bus.HLDA           = 1'b0;
        bus.wordCountIn    = '0;
        bus.blockMode      = 1'b0;
        bus.transferType   = 2'b00;
        bus.EOP_N_in       = 1'b1;
        reset = 1'b1;
        tick(); tick();
        check_idle("reset");
        check("reset_chan", bus.activeChannel, 2'd0);
        reset = 1'b0;
        tick();
        check_idle("idle");

        // S0 abandoned when the request disappears before HLDA
        start(3, 1'b1, 2'b01, 1);
        tick();
        check("s0_abort_hrq", bus.HRQ, 1'b1);
        bus.requestPending = 1'b0;
        tick();
        check_idle("s0_abort");

        run_txn(5, 1'b0, 2'b01, 0, 0, 1);     // single write
        run_txn(2, 1'b1, 2'b10, 2, 0, 0);     // block read to TC
        run_txn(100, 1'b1, 2'b01, 1, 2, 0);   // external EOP in second word
        run_txn(1, 1'b1, 2'b01, 3, 0, 0);     // two-word block write
        run_txn(0, 1'b0, 2'b11, 1, 0, 2);     // single verify with TC
        run_txn(3, 1'b1, 2'b10, 3, 4, 0);     // TC together with external EOP

        // HLDA withdrawn in S2
        start(4, 1'b1, 2'b10, 2);
        tick();
        bus.HLDA = 1'b1;
        tick();
        bus.requestPending = 1'b0;
        tick();
        bus.HLDA = 1'b0;
        tick();
        check_idle("hlda_drop");
        tick();
        check_idle("hlda_drop_after");

        // Reset asserted mid-transfer for two cycles
        start(9, 1'b1, 2'b01, 3);
        tick();
        bus.HLDA = 1'b1;
        tick();
        bus.requestPending = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check_idle("mid_reset");
        check("mid_reset_chan", bus.activeChannel, 2'd0);
        tick();
        reset = 1'b0;
        bus.HLDA = 1'b0;
        tick();
        check_idle("after_reset");

        for (int t = 0; t < 30; t++) begin
            int cnt, ew;
            bit blk;
            cnt = $urandom_range(0, 6);
            blk = 1'($urandom_range(0, 1));
            ew  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cnt + 1) : 0;
            run_txn(cnt, blk, 2'($urandom_range(0, 3)), $urandom_range(0, 3), ew,
                    $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
